// File: rtl/jesd204_versal_gt_tx_reset_seq.sv
// GT TX bring-up sequencer: PLL lock wait, GT reset pulse, reset-done wait, settle, then link release.
// Define JESD204_TX_RESET_TIMEOUT_EN to enable WAIT_DONE timeout with bounded retries and a FAULT state.
module jesd204_versal_gt_tx_reset_seq #(
  parameter int RESET_CYCLES   = 16,
  parameter int SETTLE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_pll_lock,
  input  logic       i_gt_tx_resetdone,
  output logic       o_gt_tx_reset,
  output logic       o_gt_tx_userrdy,
  output logic       o_link_reset,
  output logic       o_ready,
  output logic       o_fault,
  output logic [2:0] o_status_state,
  output logic [3:0] o_retry_count
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_PLL  = 3'd1,
    ST_GT_RST    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_READY     = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  localparam logic [23:0] RST_LAST    = 24'(RESET_CYCLES - 1);
  localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [23:0] r_cnt;

`ifdef JESD204_TX_RESET_TIMEOUT_EN
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRIES);
  logic [3:0] r_retry;
  logic [3:0] w_retry_next;
  logic       r_fault;
  assign o_retry_count = r_retry;
  assign o_fault       = r_fault;
`else
  logic w_unused_params;
  assign w_unused_params = ^{TIMEOUT_CYCLES[0], MAX_RETRIES[0]};
  assign o_retry_count   = 4'd0;
  assign o_fault         = 1'b0;
`endif

  // enable=0 is checked first so it outranks PLL loss and every other exit.
  always_comb begin
    w_state_next = r_state;
`ifdef JESD204_TX_RESET_TIMEOUT_EN
    w_retry_next = r_retry;
`endif
    if (!i_enable) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_WAIT_PLL;
`ifdef JESD204_TX_RESET_TIMEOUT_EN
          w_retry_next = 4'd0;
`endif
        end
        ST_WAIT_PLL:
          if (i_pll_lock) w_state_next = ST_GT_RST;
        ST_GT_RST:
          if (!i_pll_lock)          w_state_next = ST_WAIT_PLL;
          else if (r_cnt == RST_LAST) w_state_next = ST_WAIT_DONE;
        ST_WAIT_DONE:
          if (!i_pll_lock)             w_state_next = ST_WAIT_PLL;
          else if (i_gt_tx_resetdone)  w_state_next = ST_SETTLE;
`ifdef JESD204_TX_RESET_TIMEOUT_EN
          else if (r_cnt == TIMEOUT_LAST) begin
            if (r_retry == RETRY_MAX) begin
              w_state_next = ST_FAULT;
            end else begin
              w_state_next = ST_GT_RST;
              w_retry_next = r_retry + 4'd1;
            end
          end
`endif
        ST_SETTLE:
          if (!i_pll_lock)               w_state_next = ST_WAIT_PLL;
          else if (!i_gt_tx_resetdone)   w_state_next = ST_GT_RST;
          else if (r_cnt == SETTLE_LAST) w_state_next = ST_READY;
        ST_READY:
          if (!i_pll_lock)             w_state_next = ST_WAIT_PLL;
          else if (!i_gt_tx_resetdone) w_state_next = ST_GT_RST;
        ST_FAULT:
          w_state_next = ST_FAULT;
        default:
          w_state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= ST_IDLE;
      r_cnt           <= 24'd0;
      o_gt_tx_reset   <= 1'b1;
      o_gt_tx_userrdy <= 1'b0;
      o_link_reset    <= 1'b1;
      o_ready         <= 1'b0;
      o_status_state  <= 3'd0;
`ifdef JESD204_TX_RESET_TIMEOUT_EN
      r_retry         <= 4'd0;
      r_fault         <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state || w_state_next == ST_IDLE)
        r_cnt <= 24'd0;
      else if (r_cnt != 24'hFF_FFFF)
        r_cnt <= r_cnt + 24'd1;
      o_gt_tx_reset   <= (w_state_next == ST_IDLE) || (w_state_next == ST_WAIT_PLL) ||
                         (w_state_next == ST_GT_RST) || (w_state_next == ST_FAULT);
      o_gt_tx_userrdy <= (w_state_next == ST_WAIT_DONE) || (w_state_next == ST_SETTLE) ||
                         (w_state_next == ST_READY);
      o_link_reset    <= (w_state_next != ST_READY);
      o_ready         <= (w_state_next == ST_READY);
      o_status_state  <= w_state_next;
`ifdef JESD204_TX_RESET_TIMEOUT_EN
      r_retry         <= w_retry_next;
      r_fault         <= (w_state_next == ST_FAULT);
`endif
    end
  end

endmodule

// File: doc/jesd204_versal_gt_tx_reset_seq.md
JESD204_VERSAL_GT_TX_RESET_SEQ -- requirements
Module: jesd204_versal_gt_tx_reset_seq

Interface
REQ-001 Parameter RESET_CYCLES, default 16: cycles gt_tx_reset is held in state GT_RST (legal 1..255).
REQ-002 Parameter SETTLE_CYCLES, default 64: cycles spent in SETTLE after GT reset-done (legal 1..65535).
REQ-003 Parameter TIMEOUT_CYCLES, default 65536: maximum cycles allowed in WAIT_DONE (legal 2..2^24).
REQ-004 Parameter MAX_RETRIES, default 3: GT reset retries before FAULT (legal 1..15).
REQ-005 clk  input  1  single clock, same domain as GT TX usr_clk; reset is synchronous and active-high.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 enable  input  1  level request to bring up the TX datapath.
REQ-008 pll_lock  input  1  GT TX PLL locked, synchronous to clk.
REQ-009 gt_tx_resetdone  input  1  GT TX reset-done status, synchronous to clk.
REQ-010 gt_tx_reset  output  1  GT TX datapath reset.
REQ-011 gt_tx_userrdy  output  1  user clock stable indication to GT.
REQ-012 link_reset  output  1  holds the link layer and GT TX adapter pipeline in reset.
REQ-013 ready  output  1  TX path up; link data is valid toward the adapter.
REQ-014 fault  output  1  retries exhausted.
REQ-015 status_state  output  3  current state encoding.
REQ-016 retry_count  output  4  GT resets retried since leaving IDLE.

Function
REQ-017 States and encodings SHALL be IDLE=0, WAIT_PLL=1, GT_RST=2, WAIT_DONE=3, SETTLE=4, READY=5, FAULT=6. All outputs SHALL be registered with no combinational input-to-output path.
REQ-018 In IDLE, enable=1 SHALL move to WAIT_PLL on the next edge and clear retry_count.
REQ-019 In WAIT_PLL, pll_lock=1 SHALL move to GT_RST and load the cycle counter.
REQ-020 GT_RST SHALL last exactly RESET_CYCLES cycles with gt_tx_reset=1, then move to WAIT_DONE.
REQ-021 WAIT_DONE SHALL assert gt_tx_userrdy and move to SETTLE on gt_tx_resetdone=1.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles and then move to READY. gt_tx_resetdone=0 during SETTLE SHALL cause a return to GT_RST without incrementing retry_count.
REQ-023 In READY, ready=1 and link_reset=0. ready SHALL be 1 only in READY, and link_reset SHALL be 0 only in READY.
REQ-024 gt_tx_reset SHALL be 1 in IDLE, WAIT_PLL, GT_RST and FAULT. gt_tx_userrdy SHALL be 1 in WAIT_DONE, SETTLE and READY.
REQ-025 pll_lock=0 in GT_RST, WAIT_DONE, SETTLE or READY SHALL move to WAIT_PLL on the next edge; ready SHALL drop that same edge.
REQ-026 gt_tx_resetdone=0 in READY SHALL move to GT_RST.
REQ-027 enable=0 in any state except IDLE SHALL move to IDLE, including from FAULT. It SHALL take priority over every other transition.
REQ-028 When enable=0 and pll_lock=0 occur in the same cycle, the transition SHALL be to IDLE.
REQ-029 The cycle counter SHALL be 24 bits, shared across states, and reloaded on every state entry. It SHALL NOT wrap: it stops at terminal count.
REQ-030 fault SHALL be 1 only in FAULT. FAULT SHALL be exited only via enable=0 or reset.

Reset
REQ-031 reset=1 SHALL force IDLE on the next clk edge, overriding all inputs, including mid-sequence.
REQ-032 While in or after reset, the outputs SHALL be gt_tx_reset=1, gt_tx_userrdy=0, link_reset=1, ready=0, fault=0, status_state=0, retry_count=0, cycle counter=0.

Configuration
REQ-033 Macro JESD204_TX_RESET_TIMEOUT_EN defined: a WAIT_DONE stay reaching TIMEOUT_CYCLES SHALL increment retry_count and return to GT_RST. If retry_count already equals MAX_RETRIES, it SHALL move to FAULT instead.
REQ-034 Macro JESD204_TX_RESET_TIMEOUT_EN undefined: WAIT_DONE SHALL wait indefinitely, FAULT SHALL be unreachable, fault and retry_count SHALL be tied to 0, and no timeout logic SHALL be synthesized.

Verification
REQ-035 Nominal bring-up (defaults): reset 4 cycles, enable=1, pll_lock=1, gt_tx_resetdone rising 10 cycles after WAIT_DONE entry -> gt_tx_reset high exactly 16 cycles in GT_RST, ready=1 exactly 64 cycles after resetdone is sampled, status_state=5.
REQ-036 PLL loss in READY: pll_lock=0 for 1 cycle -> next edge ready=0, link_reset=1, status_state=1. Relock -> full GT_RST/SETTLE sequence repeats.
REQ-037 Timeout with macro defined, TIMEOUT_CYCLES=100, MAX_RETRIES=2, resetdone held 0 -> retry_count steps 1,2, then status_state=6, fault=1, gt_tx_reset=1. Then enable=0 -> IDLE, fault=0.
REQ-038 Same stimulus as REQ-037 with macro undefined -> stays in WAIT_DONE (status_state=3) for 1000 cycles, fault=0, retry_count=0.
REQ-039 Reset mid-SETTLE (cycle 30 of 64) -> next edge status_state=0 with all REQ-032 values. After release with enable=1 -> sequence restarts from WAIT_PLL.
REQ-040 Simultaneous enable=0 and pll_lock=0 in READY -> status_state=0, not 1. resetdone drop in SETTLE -> GT_RST with retry_count unchanged.
